search_dispatch: RTL and testbench

Lookup front end for the binary search table. Accepts tagged 48-bit key lookups from the packet parser into a small FIFO and issues them one at a time over the table's `req`/`rdy`/`done` handshake. Returns each result with its tag, in order, through a valid/ready output register. A watchdog converts a lost `done` into a flagged miss so the pipeline never stalls.

---
 rtl/search_dispatch_if.sv | 29 ++
 rtl/search_dispatch.sv | 157 +++++++++++++++
 tb/tb_search_dispatch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/search_dispatch_if.sv
// search_dispatch_if: request and result streams of the search front end.
//   in_valid/in_key/in_tag/in_ready        : tagged key lookups from the parser
//   out_valid/out_tag/out_found/out_result/
//   out_timeout/out_ready                  : in-order results to the consumer
// master = parser/consumer side, slave = search_dispatch.
interface search_dispatch_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic [47:0]      in_key;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             out_found;
    logic [15:0]      out_result;
    logic             out_timeout;
    logic             out_ready;

    modport master (
        output in_valid, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_tag, out_found, out_result, out_timeout
    );

    modport slave (
        input  in_valid, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_tag, out_found, out_result, out_timeout
    );
endinterface

// File: rtl/search_dispatch.sv
// search_dispatch: lookup front end for the binary search table.
// Buffers tagged 48-bit key lookups in a DEPTH-entry FIFO, issues them one at
// a time over the table req/rdy/done handshake, and returns each result with
// its tag in push order through a valid/ready result register. A watchdog
// turns a lost tbl_done into a flagged miss after TIMEOUT cycles.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   io (slave)   : request stream in, result stream out
//   tbl_req      : one-cycle lookup strobe; tbl_search holds the key
//   tbl_rdy      : table idle; tbl_done/tbl_found/tbl_result: completion
//   level        : FIFO occupancy; busy: FSM active or FIFO non-empty
module search_dispatch #(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic                       clk,
    input  logic                       reset,
    search_dispatch_if.slave           io,
    output logic                       tbl_req,
    output logic [47:0]                tbl_search,
    input  logic                       tbl_rdy,
    input  logic                       tbl_done,
    input  logic                       tbl_found,
    input  logic [15:0]                tbl_result,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(TIMEOUT+1);
    localparam int ENT_W = 48 + TAG_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   head;
    logic [CNT_W-1:0]   cnt_q;
    logic [47:0]        tbl_search_q;
    logic [TAG_W-1:0]   tag_q;
    logic               tbl_req_q;
    logic               out_valid_q, out_found_q, out_timeout_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [15:0]        out_result_q;
    logic               push, pop, full;

    // Full is judged on the registered level only, so a pop in the same
    // cycle never opens room for a push.
    assign full = (level_q == LVL_W'(DEPTH));
    assign push = io.in_valid && !full;
    assign pop  = (state_q == IDLE) && (level_q != '0) && tbl_rdy;
    assign head = mem[rd_ptr_q];

    // ---------------- FIFO ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {io.in_key, io.in_tag};
    end

    // ---------------- dispatch FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tbl_search_q  <= '0;
            tag_q         <= '0;
            tbl_req_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_found_q   <= 1'b0;
            out_result_q  <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            tbl_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tbl_search_q <= head[ENT_W-1:TAG_W];
                        tag_q        <= head[TAG_W-1:0];
                        tbl_req_q    <= 1'b1;   // high for the ISSUE cycle only
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // done takes priority over an expiry in the same cycle
                    if (tbl_done) begin
                        out_valid_q   <= 1'b1;
                        out_tag_q     <= tag_q;
                        out_found_q   <= tbl_found;
                        out_result_q  <= tbl_found ? tbl_result : 16'h0;
                        out_timeout_q <= 1'b0;
                        state_q       <= HOLD;
                    end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                        out_valid_q   <= 1'b1;
                        out_tag_q     <= tag_q;
                        out_found_q   <= 1'b0;
                        out_result_q  <= 16'h0;
                        out_timeout_q <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready    = !full;
    assign io.out_valid   = out_valid_q;
    assign io.out_tag     = out_tag_q;
    assign io.out_found   = out_found_q;
    assign io.out_result  = out_result_q;
    assign io.out_timeout = out_timeout_q;
    assign tbl_req        = tbl_req_q;
    assign tbl_search     = tbl_search_q;
    assign level          = level_q;
    assign busy           = (state_q != IDLE) || (level_q != '0);
endmodule

// File: tb/tb_search_dispatch.sv
module tb_search_dispatch;
    localparam int DEPTH = 8, TAG_W = 8, TIMEOUT = 16;

    logic        clk = 0, reset = 1;
    logic        tbl_req, tbl_rdy, tbl_done, tbl_found, busy;
    logic [47:0] tbl_search;
    logic [15:0] tbl_result;
    logic [3:0]  level;

    search_dispatch_if #(.TAG_W(TAG_W)) bus();

    search_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .io(bus),
        .tbl_req(tbl_req), .tbl_search(tbl_search), .tbl_rdy(tbl_rdy),
        .tbl_done(tbl_done), .tbl_found(tbl_found), .tbl_result(tbl_result),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  tag;
        logic        found;
        logic [15:0] result;
        logic        timeout;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;
    int req_count = 0, req_cyc = 0, out_rise = 0, n_results = 0, push_cyc = 0;
    logic req_prev = 0, ov_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- table model ----------------
    logic        done_m = 0, found_m = 0, done_x = 0;
    logic [15:0] result_m = 0;
    int          cfg_delay = 1;
    logic        cfg_found = 1, cfg_echo = 0, cfg_never = 0;
    logic [15:0] cfg_result = 0;

    assign tbl_done   = done_m | done_x;
    assign tbl_found  = found_m | done_x;          // injected strobes claim a hit
    assign tbl_result = done_x ? 16'hBEEF : result_m;

    initial begin
        logic [47:0] k;
        forever begin
            @(negedge clk);
            if (tbl_req && !cfg_never) begin
                k = tbl_search;
                repeat (cfg_delay) @(posedge clk);
                #1;
                done_m   = 1;
                found_m  = cfg_found;
                result_m = cfg_echo ? k[15:0] : cfg_result;
                @(posedge clk);
                #1 done_m = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tbl_req) begin
                req_count++;
                req_cyc = cyc;
                check("tbl_req_one_cycle", req_prev, 0);
            end
            req_prev = tbl_req;
            if (bus.out_valid && !ov_prev) out_rise = cyc;
            ov_prev = bus.out_valid;
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got tag %0h expected none", bus.out_tag);
                end else begin
                    e = sb.pop_front();
                    n_results++;
                    check("out_tag", bus.out_tag, e.tag);
                    check("out_found", bus.out_found, e.found);
                    check("out_result", bus.out_result, e.result);
                    check("out_timeout", bus.out_timeout, e.timeout);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push(input logic [47:0] k, input logic [7:0] t);
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1; bus.in_key = k; bus.in_tag = t;
        while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check("push_timeout", 1, 0);
        push_cyc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic expect_res(input logic [7:0] t, input logic f, input logic [15:0] r, input logic to);
        exp_t e;
        e.tag = t; e.found = f; e.result = r; e.timeout = to;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while ((sb.size() != 0 || bus.out_valid) && k < bound) begin @(negedge clk); k++; end
        check("drain_in_time", k < bound, 1);
    endtask

    task automatic wait_req(input int n0);
        int k = 0;
        while (req_count == n0 && k < 200) begin @(negedge clk); k++; end
        check("req_in_time", k < 200, 1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.out_valid && k < 200) begin @(negedge clk); k++; end
        check("valid_in_time", k < 200, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0, n0, o0, pop_cyc;
        logic stable;
        logic [63:0] snap;
        bus.in_valid = 0; bus.in_key = 0; bus.in_tag = 0; bus.out_ready = 1;
        tbl_rdy = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_tbl_req", tbl_req, 0);
        check("rst_tbl_search", tbl_search, 0);
        reset = 0;

        // hit: done 3 cycles after req
        cfg_echo = 0; cfg_found = 1; cfg_result = 16'd1; cfg_delay = 3;
        expect_res(8'd3, 1, 16'd1, 0);
        push(48'h84, 8'd3);
        wait_drain(100);
        check("hit_req_latency", req_cyc - push_cyc, 2);
        check("hit_out_latency", out_rise - push_cyc, 6);
        check("hit_search", tbl_search, 48'h84);

        // miss with garbage result: minimum latency path
        cfg_found = 0; cfg_result = 16'hFFFF; cfg_delay = 1;
        expect_res(8'd5, 0, 16'd0, 0);
        push(48'h99, 8'd5);
        wait_drain(100);
        check("miss_out_latency", out_rise - push_cyc, 4);

        // full FIFO
        cfg_echo = 1; cfg_found = 1; cfg_delay = 1;
        tbl_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            expect_res(i[7:0], 1, 16'h1000 + 16'(i), 0);
            push(48'h1000 + 48'(i), i[7:0]);
        end
        @(posedge clk); #1;
        bus.in_valid = 1; bus.in_key = 48'h1008; bus.in_tag = 8'd8;
        check("full_in_ready", bus.in_ready, 0);
        check("full_level", level, 8);
        @(posedge clk); #1;
        check("full_level_held", level, 8);
        bus.in_valid = 0;
        tbl_rdy = 1;
        wait_drain(500);
        check("full_drained_level", level, 0);
        check("full_results", n_results, 10);

        // timeout, then late done in HOLD and IDLE
        cfg_never = 1; bus.out_ready = 0;
        expect_res(8'd7, 0, 16'd0, 1);
        push(48'h77, 8'd7);
        wait_valid();
        check("timeout_latency", out_rise - req_cyc, TIMEOUT + 1);
        @(posedge clk); #1 done_x = 1;
        @(posedge clk); #1 done_x = 0;
        check("hold_late_found", bus.out_found, 0);
        check("hold_late_timeout", bus.out_timeout, 1);
        check("hold_late_result", bus.out_result, 0);
        bus.out_ready = 1;
        wait_drain(100);
        n0 = n_results;
        @(posedge clk); #1 done_x = 1;
        @(posedge clk); #1 done_x = 0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_late_no_result", n_results, n0);
        check("idle_late_out_valid", bus.out_valid, 0);
        cfg_never = 0;

        // backpressure with two queued
        bus.out_ready = 0; cfg_delay = 1;
        expect_res(8'h21, 1, 16'h2001, 0);
        expect_res(8'h22, 1, 16'h2002, 0);
        push(48'h2001, 8'h21);
        push(48'h2002, 8'h22);
        wait_valid();
        @(posedge clk); #1;
        snap = {bus.out_valid, bus.out_tag, bus.out_found, bus.out_result, bus.out_timeout};
        r0 = req_count; stable = 1;
        repeat (10) begin
            @(negedge clk);
            if ({bus.out_valid, bus.out_tag, bus.out_found, bus.out_result, bus.out_timeout} != snap)
                stable = 0;
        end
        check("bp_stable", stable, 1);
        check("bp_no_second_req", req_count, r0);
        @(posedge clk); #1;
        bus.out_ready = 1; pop_cyc = cyc;
        wait_req(r0);
        check("bp_reissue_gap", req_cyc - pop_cyc, 2);
        wait_drain(100);

        // reset mid-WAIT with 3 entries queued
        cfg_delay = 6; tbl_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            expect_res(8'h40 + 8'(i), 1, 16'h3000 + 16'(i), 0);
            push(48'h3000 + 48'(i), 8'h40 + 8'(i));
        end
        r0 = req_count;
        tbl_rdy = 1;
        wait_req(r0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_level", level, 3);
        reset = 1; sb.delete();
        @(posedge clk); #1;
        check("wrst_level", level, 0);
        check("wrst_in_ready", bus.in_ready, 1);
        check("wrst_busy", busy, 0);
        check("wrst_out_tag", bus.out_tag, 0);
        check("wrst_out_found", bus.out_found, 0);
        check("wrst_out_result", bus.out_result, 0);
        check("wrst_tbl_search", tbl_search, 0);
        reset = 0;
        r0 = req_count; n0 = n_results; o0 = out_rise;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_no_req", req_count, r0);
        check("post_rst_no_result", n_results, n0);
        check("post_rst_no_valid", out_rise, o0);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
